// File: rtl/reservation_station.sv
// reservation_station
//   Tomasulo-style issue/execute back end. Each clock it accepts one decoded
//   instruction, renames its destination through a register status table, and
//   executes it on internal units: add/mv (tags 0-1), mul (tags 2-3), and an
//   in-order load/store FIFO (tags 4-7) with a private data memory. One result
//   per cycle is broadcast on the common data bus (CDB).
//   Optional macro RS_BYPASS_EN: the read port forwards the CDB value in the
//   broadcast cycle instead of showing it one cycle later.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   unit              000 lw, 001 sw, 010 add, 011 mul, 100 mv, 101 halt
//   reg1/reg2/reg3    dest (sw: store data), source A / base, source B
//   hasimm, imm       use imm in place of reg3 (mv: in place of reg2)
//   enable, out       issue request; out=1 means the request is not taken
//   regread, regin    read-port enable (informational) and register index
//   regout, regoutrf  status tag (7F = ready) and register file value of regin
module reservation_station #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 6,
  parameter int UNIT_SIZE = 8,
  parameter int MEM_DEPTH = 256   // power of two: address wraps modulo depth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           unit,
  input  logic [REG_SIZE-1:0]  reg1,
  input  logic [REG_SIZE-1:0]  reg2,
  input  logic [REG_SIZE-1:0]  reg3,
  input  logic                 hasimm,
  input  logic [WORD_SIZE-1:0] imm,
  input  logic                 enable,
  output logic                 out,
  input  logic                 regread,
  input  logic [REG_SIZE-1:0]  regin,
  output logic [UNIT_SIZE-1:0] regout,
  output logic [WORD_SIZE-1:0] regoutrf
);

  localparam int NREG = 1 << REG_SIZE;
  localparam int NST  = 8;
  localparam int AW   = $clog2(MEM_DEPTH);
  localparam logic [UNIT_SIZE-1:0] NO_TAG = UNIT_SIZE'(8'h7F);
  localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_MV   = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } st_e;

  // Initial operand: ready register value, same-cycle broadcast, or producer tag.
  function automatic logic [UNIT_SIZE+WORD_SIZE-1:0] capture(
    input logic [UNIT_SIZE-1:0] stat,
    input logic [WORD_SIZE-1:0] val,
    input logic                 bv,
    input logic [UNIT_SIZE-1:0] btag,
    input logic [WORD_SIZE-1:0] bval
  );
    if (stat == NO_TAG)
      capture = {NO_TAG, val};
    else if (bv && (stat == btag))
      capture = {NO_TAG, bval};
    else
      capture = {stat, ZERO_W};
  endfunction

  // Execute cycles minus one; the EXEC state counts this down to zero.
  function automatic logic [1:0] lat_m1(input logic [2:0] op);
    case (op)
      OP_MUL:  lat_m1 = 2'd2;
      OP_LW:   lat_m1 = 2'd1;
      default: lat_m1 = 2'd0;
    endcase
  endfunction

  st_e                  st_r     [NST];
  st_e                  st_nxt_s [NST];
  logic [2:0]           op_r     [NST];
  logic [WORD_SIZE-1:0] va_r [NST], vb_r [NST], vd_r [NST], res_r [NST];
  logic [UNIT_SIZE-1:0] qa_r [NST], qb_r [NST], qd_r [NST];
  logic [1:0]           cnt_r    [NST];
  logic [NST-1:0]       rdy_r;
  logic [UNIT_SIZE-1:0] status_r [NREG];
  logic [WORD_SIZE-1:0] rf_r     [NREG];
  logic [WORD_SIZE-1:0] mem_r    [MEM_DEPTH];
  logic                 halted_r;
  logic [1:0]           head_r, tail_r;
  logic [2:0]           ls_cnt_r;

  logic                 avail_s, alloc_s, dest_s;
  logic [2:0]           new_idx_s, head_idx_s, cdb_idx_s;
  logic                 cdb_v_s, sw_done_s, ls_free_s;
  logic [UNIT_SIZE-1:0] cdb_tag_s;
  logic [WORD_SIZE-1:0] cdb_val_s;
  logic [AW-1:0]        sw_addr_s;
  logic [NST-1:0]       elig_s, start_s;
  logic [WORD_SIZE-1:0] start_res_s [NST];
  logic [UNIT_SIZE+WORD_SIZE-1:0] cap_a_s, cap_b_s, cap_d_s;
  logic                 unused_regread_s;

  assign unused_regread_s = regread;
  assign head_idx_s = {1'b1, head_r};

  // Class availability, stall output and choice of the station to allocate.
  always_comb begin
    avail_s   = 1'b1;
    new_idx_s = 3'd0;
    case (unit)
      OP_ADD, OP_MV: begin
        avail_s   = (st_r[0] == ST_FREE) || (st_r[1] == ST_FREE);
        new_idx_s = (st_r[0] == ST_FREE) ? 3'd0 : 3'd1;
      end
      OP_MUL: begin
        avail_s   = (st_r[2] == ST_FREE) || (st_r[3] == ST_FREE);
        new_idx_s = (st_r[2] == ST_FREE) ? 3'd2 : 3'd3;
      end
      OP_LW, OP_SW: begin
        avail_s   = (ls_cnt_r != 3'd4);
        new_idx_s = {1'b1, tail_r};
      end
      default: begin
        avail_s   = 1'b1;   // halt and unknown codes need no station
        new_idx_s = 3'd0;
      end
    endcase
    out     = enable & (halted_r | ~avail_s);
    alloc_s = enable & ~out & (unit <= OP_MV);
    dest_s  = alloc_s & (unit != OP_SW);
  end

  // CDB arbitration: lowest finished tag broadcasts, the rest hold.
  always_comb begin
    cdb_v_s   = 1'b0;
    cdb_idx_s = 3'd0;
    for (int i = NST - 1; i >= 0; i--) begin
      cdb_v_s   = (st_r[i] == ST_DONE) ? 1'b1 : cdb_v_s;
      cdb_idx_s = (st_r[i] == ST_DONE) ? 3'(i) : cdb_idx_s;
    end
    cdb_tag_s = UNIT_SIZE'(cdb_idx_s);
    cdb_val_s = res_r[cdb_idx_s];
  end

  // Initial tag/value for each operand of the incoming instruction.
  always_comb begin
    if ((unit == OP_MV) && hasimm)
      cap_a_s = {NO_TAG, imm};
    else
      cap_a_s = capture(status_r[reg2], rf_r[reg2], cdb_v_s, cdb_tag_s, cdb_val_s);
    if (unit == OP_MV)
      cap_b_s = {NO_TAG, ZERO_W};
    else if (hasimm)
      cap_b_s = {NO_TAG, imm};
    else
      cap_b_s = capture(status_r[reg3], rf_r[reg3], cdb_v_s, cdb_tag_s, cdb_val_s);
    if (unit == OP_SW)
      cap_d_s = capture(status_r[reg1], rf_r[reg1], cdb_v_s, cdb_tag_s, cdb_val_s);
    else
      cap_d_s = {NO_TAG, ZERO_W};
  end

  // Execute start selection per unit and the result each unit would produce.
  always_comb begin
    for (int i = 0; i < NST; i++)
      elig_s[i] = (st_r[i] == ST_WAIT) & rdy_r[i];
    start_s = '0;
    if ((st_r[0] != ST_EXEC) && (st_r[1] != ST_EXEC)) begin
      start_s[0] = elig_s[0];
      start_s[1] = elig_s[1] & ~elig_s[0];
    end else begin
      start_s[1:0] = 2'b00;
    end
    // the mul unit is not pipelined: one multiply in flight at a time
    if ((st_r[2] != ST_EXEC) && (st_r[3] != ST_EXEC)) begin
      start_s[2] = elig_s[2];
      start_s[3] = elig_s[3] & ~elig_s[2];
    end else begin
      start_s[3:2] = 2'b00;
    end
    // only the FIFO head may execute, which keeps loads behind older stores
    for (int i = 4; i < NST; i++)
      start_s[i] = elig_s[i] & (3'(i) == head_idx_s);
    for (int i = 0; i < 2; i++)
      start_res_s[i] = (op_r[i] == OP_MV) ? va_r[i] : (va_r[i] + vb_r[i]);
    for (int i = 2; i < 4; i++)
      start_res_s[i] = WORD_SIZE'($signed(va_r[i]) * $signed(vb_r[i]));
    for (int i = 4; i < NST; i++)
      start_res_s[i] = mem_r[AW'(va_r[i] + vb_r[i])];
    sw_addr_s = AW'(va_r[head_idx_s] + vb_r[head_idx_s]);
    sw_done_s = (st_r[head_idx_s] == ST_EXEC) && (cnt_r[head_idx_s] == 2'd0) &&
                (op_r[head_idx_s] == OP_SW);
    ls_free_s = sw_done_s | (cdb_v_s & (cdb_idx_s == head_idx_s));
  end

  // Station next-state logic.
  always_comb begin
    for (int i = 0; i < NST; i++) begin
      st_nxt_s[i] = st_r[i];
      case (st_r[i])
        ST_FREE: st_nxt_s[i] = (alloc_s && (new_idx_s == 3'(i))) ? ST_WAIT : ST_FREE;
        ST_WAIT: st_nxt_s[i] = start_s[i] ? ST_EXEC : ST_WAIT;
        ST_EXEC: begin
          if (cnt_r[i] != 2'd0)
            st_nxt_s[i] = ST_EXEC;
          else
            st_nxt_s[i] = (op_r[i] == OP_SW) ? ST_FREE : ST_DONE;  // sw never uses the CDB
        end
        ST_DONE: st_nxt_s[i] = (cdb_v_s && (cdb_idx_s == 3'(i))) ? ST_FREE : ST_DONE;
        default: st_nxt_s[i] = ST_FREE;
      endcase
    end
  end

  // Station state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NST; i++) st_r[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < NST; i++) st_r[i] <= st_nxt_s[i];
    end
  end

  // Station payload: operands, CDB snooping, results and latency counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NST; i++) begin
        op_r[i]  <= 3'd0;
        va_r[i]  <= ZERO_W;
        vb_r[i]  <= ZERO_W;
        vd_r[i]  <= ZERO_W;
        res_r[i] <= ZERO_W;
        qa_r[i]  <= NO_TAG;
        qb_r[i]  <= NO_TAG;
        qd_r[i]  <= NO_TAG;
        cnt_r[i] <= 2'd0;
      end
      rdy_r <= '0;
    end else begin
      for (int i = 0; i < NST; i++) begin
        // eligibility trails operand readiness by one cycle
        rdy_r[i] <= (st_r[i] == ST_WAIT) && (qa_r[i] == NO_TAG) &&
                    (qb_r[i] == NO_TAG) && (qd_r[i] == NO_TAG);
        if (alloc_s && (new_idx_s == 3'(i))) begin
          op_r[i]           <= unit;
          {qa_r[i], va_r[i]} <= cap_a_s;
          {qb_r[i], vb_r[i]} <= cap_b_s;
          {qd_r[i], vd_r[i]} <= cap_d_s;
        end else begin
          if ((st_r[i] == ST_WAIT) && cdb_v_s) begin
            if (qa_r[i] == cdb_tag_s) begin qa_r[i] <= NO_TAG; va_r[i] <= cdb_val_s; end
            if (qb_r[i] == cdb_tag_s) begin qb_r[i] <= NO_TAG; vb_r[i] <= cdb_val_s; end
            if (qd_r[i] == cdb_tag_s) begin qd_r[i] <= NO_TAG; vd_r[i] <= cdb_val_s; end
          end
          if (start_s[i]) begin
            res_r[i] <= start_res_s[i];
            cnt_r[i] <= lat_m1(op_r[i]);
          end else if ((st_r[i] == ST_EXEC) && (cnt_r[i] != 2'd0)) begin
            cnt_r[i] <= cnt_r[i] - 2'd1;
          end
        end
      end
    end
  end

  // Register file, status table, data memory, FIFO pointers and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        status_r[r] <= NO_TAG;
        rf_r[r]     <= ZERO_W;
      end
      for (int m = 0; m < MEM_DEPTH; m++) mem_r[m] <= ZERO_W;
      halted_r <= 1'b0;
      head_r   <= 2'd0;
      tail_r   <= 2'd0;
      ls_cnt_r <= 3'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (cdb_v_s && (status_r[r] == cdb_tag_s)) begin
          rf_r[r]     <= cdb_val_s;
          status_r[r] <= NO_TAG;
        end
      end
      // issued after source capture, so the new tag wins over a same-edge writeback
      if (dest_s) status_r[reg1] <= UNIT_SIZE'(new_idx_s);
      if (sw_done_s) mem_r[sw_addr_s] <= vd_r[head_idx_s];
      if (enable && !out && (unit == OP_HALT)) halted_r <= 1'b1;
      if (alloc_s && new_idx_s[2]) tail_r <= tail_r + 2'd1;
      if (ls_free_s) head_r <= head_r + 2'd1;
      ls_cnt_r <= ls_cnt_r + {2'b00, alloc_s & new_idx_s[2]} - {2'b00, ls_free_s};
    end
  end

  // Read port used by fetch for branch resolution.
  always_comb begin
`ifdef RS_BYPASS_EN
    if (cdb_v_s && (status_r[regin] == cdb_tag_s)) begin
      regout   = NO_TAG;
      regoutrf = cdb_val_s;
    end else begin
      regout   = status_r[regin];
      regoutrf = rf_r[regin];
    end
`else
    regout   = status_r[regin];
    regoutrf = rf_r[regin];
`endif
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  unit = 3'd0;
  logic [5:0]  reg1 = 6'd0, reg2 = 6'd0, reg3 = 6'd0, regin = 6'd0;
  logic        hasimm = 1'b0, enable = 1'b0, regread = 1'b1;
  logic [31:0] imm = 32'd0;
  logic        out;
  logic [7:0]  regout;
  logic [31:0] regoutrf;

  int nvec = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  // architectural model: sequential program semantics, updated at issue
  logic [31:0] mrf  [64];
  logic [31:0] mmem [256];
  int          mcls [64];   // 0 add/mv, 1 mul, 2 lw, 3 never renamed
  bit          mhalt;

  reservation_station dut (
    .clk(clk), .rst(rst), .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .hasimm(hasimm), .imm(imm), .enable(enable), .out(out), .regread(regread),
    .regin(regin), .regout(regout), .regoutrf(regoutrf)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int r = 0; r < 64; r++) begin mrf[r] = 32'd0; mcls[r] = 3; end
    for (int m = 0; m < 256; m++) mmem[m] = 32'd0;
    mhalt = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] u, input logic [5:0] d, s1, s2,
                             input logic hi, input logic [31:0] im);
    logic [31:0] a, b;
    longint p;
    a = mrf[s1];
    b = hi ? im : mrf[s2];
    case (u)
      3'b010: begin mrf[d] = a + b; mcls[d] = 0; end
      3'b011: begin p = longint'($signed(a)) * longint'($signed(b)); mrf[d] = p[31:0]; mcls[d] = 1; end
      3'b100: begin mrf[d] = hi ? im : a; mcls[d] = 0; end
      3'b000: begin mrf[d] = mmem[(a + b) % 256]; mcls[d] = 2; end
      3'b001: mmem[(a + b) % 256] = mrf[d];
      3'b101: mhalt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] u, input logic [5:0] d, s1, s2,
                       input logic hi, input logic [31:0] im);
    int n;
    n = 0;
    unit = u; reg1 = d; reg2 = s1; reg3 = s2; hasimm = hi; imm = im; enable = 1'b1;
    do begin @(negedge clk); n++; end while ((out !== 1'b0) && (n < 200));
    if (out !== 1'b0) begin
      nvec++; nfail++;
      $display("FAIL issue_accept unit=%b: out=%b after %0d cycles, required 0", u, out, n);
      @(posedge clk); #1 enable = 1'b0;
    end else begin
      @(posedge clk);
      model_apply(u, d, s1, s2, hi, im);
      #1 enable = 1'b0;
    end
  endtask

  task automatic wait_reg(input logic [5:0] r, input logic [31:0] exp, input string nm);
    int n;
    n = 0;
    regin = r;
    do begin @(negedge clk); n++; end while ((regout !== 8'h7F) && (n < 200));
    nvec++;
    if (regout !== 8'h7F) begin
      nfail++;
      $display("FAIL %s: regout=%h after %0d cycles, required 7f", nm, regout, n);
    end else if (regoutrf !== exp) begin
      nfail++;
      $display("FAIL %s: regoutrf=%0d, required %0d", nm, $signed(regoutrf), $signed(exp));
    end
    @(posedge clk); #1;
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      nvec++;
      if (regout == 8'h7F) begin
        if (regoutrf !== mrf[regin]) begin
          nfail++;
          $display("FAIL model_value r%0d: regoutrf=%0d, required %0d", regin, $signed(regoutrf), $signed(mrf[regin]));
        end
      end else if (!((mcls[regin] == 0 && regout <= 8'd1) ||
                     (mcls[regin] == 1 && regout >= 8'd2 && regout <= 8'd3) ||
                     (mcls[regin] == 2 && regout >= 8'd4 && regout <= 8'd7))) begin
        nfail++;
        $display("FAIL model_tag r%0d: regout=%h, producer class %0d", regin, regout, mcls[regin]);
      end
      if (enable && mhalt) begin
        nvec++;
        if (out !== 1'b1) begin nfail++; $display("FAIL halted_stall: out=%b, required 1", out); end
      end
      if (!enable) begin
        nvec++;
        if (out !== 1'b0) begin nfail++; $display("FAIL idle_out: out=%b, required 0", out); end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #2 rst = 1'b1;
    #1;
    for (int r = 0; r < 64; r++) begin
      regin = 6'(r);
      #1;
      nvec++;
      if (regout !== 8'h7F || regoutrf !== 32'd0) begin
        nfail++;
        $display("FAIL reset_reg r%0d: regout=%h regoutrf=%h, required 7f/0", r, regout, regoutrf);
      end
    end
    nvec++;
    if (out !== enable) begin nfail++; $display("FAIL reset_out: out=%b, required %b", out, enable); end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;

    // single move
    issue(3'b100, 6'd1, 6'd0, 6'd0, 1'b1, 32'd5);
    wait_reg(6'd1, 32'd5, "mv_r1");

    // dependency chain issued back to back
    issue(3'b100, 6'd1, 6'd0, 6'd0, 1'b1, 32'd5);
    issue(3'b010, 6'd2, 6'd1, 6'd0, 1'b1, -32'sd7);
    issue(3'b011, 6'd3, 6'd2, 6'd2, 1'b0, 32'd0);
    regin = 6'd3;
    @(negedge clk);
    nvec++;
    if (regout !== 8'd2 && regout !== 8'd3) begin
      nfail++; $display("FAIL chain_tag: regout=%h, required 02 or 03", regout);
    end
    @(posedge clk); #1;
    wait_reg(6'd3, 32'd4, "chain_r3");
    wait_reg(6'd2, 32'hFFFF_FFFE, "chain_r2");

    // memory ordering, including an address that wraps modulo the depth
    issue(3'b100, 6'd4, 6'd0, 6'd0, 1'b1, 32'd100);
    issue(3'b001, 6'd4, 6'd0, 6'd0, 1'b1, 32'd3);
    issue(3'b000, 6'd5, 6'd0, 6'd0, 1'b1, 32'd3);
    wait_reg(6'd5, 32'd100, "lw_r5");
    issue(3'b100, 6'd6, 6'd0, 6'd0, 1'b1, -32'sd9);
    issue(3'b001, 6'd6, 6'd0, 6'd0, 1'b1, 32'd259);
    issue(3'b000, 6'd7, 6'd0, 6'd0, 1'b1, 32'd3);
    wait_reg(6'd7, 32'hFFFF_FFF7, "lw_wrap_r7");

    // structural stall on the mul stations
    issue(3'b011, 6'd20, 6'd3, 6'd3, 1'b0, 32'd0);
    issue(3'b011, 6'd21, 6'd20, 6'd0, 1'b1, 32'd2);
    unit = 3'b011; reg1 = 6'd22; reg2 = 6'd20; hasimm = 1'b1; imm = 32'd3; enable = 1'b1;
    @(negedge clk);
    nvec++;
    if (out !== 1'b1) begin nfail++; $display("FAIL mul_stall: out=%b, required 1", out); end
    @(posedge clk); #1;
    issue(3'b011, 6'd22, 6'd20, 6'd0, 1'b1, 32'd3);
    wait_reg(6'd22, 32'd48, "mul_r22");
    wait_reg(6'd21, 32'd32, "mul_r21");
    issue(3'b011, 6'd23, 6'd2, 6'd0, 1'b1, 32'd3);
    issue(3'b100, 6'd25, 6'd0, 6'd0, 1'b1, 32'h0001_0000);
    issue(3'b011, 6'd24, 6'd25, 6'd25, 1'b0, 32'd0);
    issue(3'b010, 6'd26, 6'd20, 6'd22, 1'b0, 32'd0);
    wait_reg(6'd23, 32'hFFFF_FFFA, "mul_neg_r23");
    wait_reg(6'd24, 32'd0, "mul_wrap_r24");
    wait_reg(6'd26, 32'd64, "add_reg_r26");

    // unknown unit code is accepted and has no effect
    issue(3'b110, 6'd1, 6'd0, 6'd0, 1'b1, 32'd77);
    wait_reg(6'd1, 32'd5, "unknown_r1");

    // halt: later requests stall, earlier work still writes back
    issue(3'b010, 6'd30, 6'd1, 6'd0, 1'b1, 32'd1);
    issue(3'b101, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0);
    unit = 3'b100; reg1 = 6'd31; hasimm = 1'b1; imm = 32'd1; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++;
      if (out !== 1'b1) begin nfail++; $display("FAIL halt_out cycle %0d: out=%b, required 1", k, out); end
    end
    @(posedge clk); #1 enable = 1'b0;
    wait_reg(6'd30, 32'd6, "halt_r30");
    wait_reg(6'd31, 32'd0, "halt_r31");

    // reset clears halt; then reset again in the middle of a multiply
    @(posedge clk); #3 rst = 1'b1; model_clear();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    issue(3'b100, 6'd40, 6'd0, 6'd0, 1'b1, 32'd7);
    issue(3'b011, 6'd41, 6'd40, 6'd40, 1'b0, 32'd0);
    regin = 6'd41;
    @(posedge clk); #3 rst = 1'b1; model_clear();
    #1;
    nvec++;
    if (regout !== 8'h7F || regoutrf !== 32'd0 || out !== enable) begin
      nfail++; $display("FAIL midreset_r41: regout=%h regoutrf=%h out=%b, required 7f/0/%b", regout, regoutrf, out, enable);
    end
    regin = 6'd40;
    #1;
    nvec++;
    if (regout !== 8'h7F || regoutrf !== 32'd0) begin
      nfail++; $display("FAIL midreset_r40: regout=%h regoutrf=%h, required 7f/0", regout, regoutrf);
    end
    @(posedge clk); #3 rst = 1'b0;
    regin = 6'd41;
    repeat (15) @(posedge clk);
    #1;
    nvec++;
    if (regout !== 8'h7F || regoutrf !== 32'd0) begin
      nfail++; $display("FAIL no_late_wb: regout=%h regoutrf=%h, required 7f/0", regout, regoutrf);
    end
    issue(3'b100, 6'd42, 6'd0, 6'd0, 1'b1, 32'd9);
    wait_reg(6'd42, 32'd9, "post_reset_r42");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
